// File: rtl/popcount_seq.sv
// Sequential popcount: one 3-bit chunk per cycle, LSB chunk first, valid/ready on both sides.
// Optional POPCOUNT_SEQ_EARLY_EXIT_EN ends RUN as soon as the remaining chunks are all zero.
module popcount_seq #(
  parameter  int WIDTH  = 16,
  localparam int NCHUNK = (WIDTH + 2) / 3,
  localparam int CW     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);
  localparam int SW = 3 * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] sh, rem;
  logic [CW-1:0] acc, acc_nx;
  logic [IW-1:0] idx;
  logic [1:0]    csum;
  logic          run_last;

  always_comb begin
    csum   = {1'b0, sh[0]} + {1'b0, sh[1]} + {1'b0, sh[2]};
    acc_nx = acc + CW'(csum);
    rem    = sh >> 3;
`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
    run_last = (idx == IW'(NCHUNK - 1)) || (rem == '0);
`else
    run_last = (idx == IW'(NCHUNK - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // out_count is its own register so it holds across the next word's accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      sh        <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh  <= SW'(in_data);
          acc <= '0;
          idx <= '0;
        end
        RUN: begin
          sh  <= rem;
          acc <= acc_nx;
          idx <= idx + IW'(1);
          if (run_last) out_count <= acc_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq (WIDTH=16): directed latency/backpressure/reset cases plus random traffic.
module tb_popcount_seq;
  logic        clk = 0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [4:0]  out_count;

  int n_cmp = 0, n_err = 0;
  int n_in = 0, n_out = 0, n_drop = 0;
  int exp_q[$];

  popcount_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pc16(input logic [15:0] d);
    int c = 0;
    for (int i = 0; i < 16; i++) c += d[i];
    return c;
  endfunction

  function automatic int lat_of(input logic [15:0] d);
`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
    int hi = 0;
    logic [17:0] w;
    w = {2'b00, d};
    for (int c = 0; c < 6; c++) if (w[3*c +: 3] != 3'b000) hi = c;
    return hi + 1;
`else
    return 6;
`endif
  endfunction

  // Handshakes are decided by signals stable since posedge+1, so sample them at negedge.
  always @(negedge clk) begin
    if (reset) begin
      n_drop += exp_q.size();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(pc16(in_data));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("count", out_count, exp_q.pop_front());
      end
    end
  end

  task automatic wait_accept(input string tag);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_valid_timeout"}, 0, 1);
  endtask

  // One word with out_ready=1; checks latency, in_ready/busy during the run, and return to IDLE.
  task automatic run_word(input string tag, input logic [15:0] d);
    int lat = 0;
    bit ok = 0;
    in_data = d; in_valid = 1;
    wait_accept(tag);
    in_valid = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1; break; end
      chk({tag, "_rdy_run"}, in_ready, 0);
      chk({tag, "_busy_run"}, busy, 1);
    end
    if (!ok) chk({tag, "_valid_timeout"}, 0, 1);
    chk({tag, "_lat"}, lat, lat_of(d));
    chk({tag, "_rdy_done"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", out_count, 0);

    run_word("full", 16'hFFFF);
    run_word("zero", 16'h0000);
    run_word("x8001", 16'h8001);
    run_word("x0007", 16'h0007);

    // Backpressure: result held, new word refused until the output handshake.
    out_ready = 0; in_data = 16'hA5A5; in_valid = 1;
    wait_accept("bp");
    in_data = 16'h1234;
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov", out_valid, 1);
      chk("bp_cnt", out_count, 8);
      chk("bp_rdy", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_idle_rdy", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    chk("bp_new_busy", busy, 1);
    wait_valid("bp2");
    @(posedge clk); #1;

    // Reset during RUN cycle 3 abandons the word and clears the held result.
    in_data = 16'h00FF; in_valid = 1;
    wait_accept("rr");
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("rr_busy", busy, 0);
    chk("rr_ov", out_valid, 0);
    chk("rr_count", out_count, 0);
    chk("rr_rdy", in_ready, 1);
    run_word("x0F0F", 16'h0F0F);

    // Random traffic with random backpressure.
    begin
      int base = n_in;
      for (int cyc = 0; cyc < 20000 && (n_in - base) < 200; cyc++) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 16'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      chk("rnd_words", (n_in - base >= 200) ? 1 : 0, 1);
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    chk("lost_or_dup", n_out + n_drop, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Sequencer that time-shares a single 3-bit population-count datapath to count set bits in a WIDTH-bit word.
- Processes one 3-bit chunk per cycle, LSB chunk first, and accumulates the chunk counts.
- Uses a valid/ready handshake on both input and output.
- Sits between a word producer and a consumer that needs the bit count, where a full-width adder tree is too costly.

Parameters:
- WIDTH, 16, input word width in bits; legal range >= 1.
- NCHUNK (derived, localparam), ceil(WIDTH/3), number of 3-bit chunks; 6 for the default.
- CW (derived, localparam), $clog2(WIDTH+1), width of the count result; 5 for the default.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to count.
- out_valid  output  1  out_count holds a final result.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CW  number of set bits in the accepted word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: the block is clocked by clk; reset is synchronous and active-high. When reset is high at a rising edge:
  - state goes to IDLE;
  - accumulator, shift register and chunk index are cleared to 0;
  - out_valid=0, out_count=0, busy=0, in_ready=1 from the next cycle.
  - Reset in any state, including mid-RUN or in DONE with out_valid high, abandons the word with no output.
- States: IDLE, RUN, DONE, implemented as a registered FSM.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch in_data into the shift register, zero-extended to 3*NCHUNK bits; acc=0; idx=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle: acc <= acc + (sh[0]+sh[1]+sh[2]); sh <= sh >> 3; idx <= idx+1.
  - On the cycle where idx==NCHUNK-1, the final add is registered and the state goes to DONE.
- DONE:
  - out_valid=1; out_count equals acc and is held stable while out_ready=0.
  - in_ready=0.
  - On out_valid && out_ready at an edge: go to IDLE and out_valid=0 next cycle.
  - out_count keeps its last value until the next result or reset.
- Latency: with the word accepted at edge E, out_valid rises after edge E+NCHUNK (6 cycles for WIDTH=16). The earliest next accept is one cycle after the output handshake, so there is no overlap of words.
- Widths:
  - The chunk sum is 2 bits (maximum 3).
  - acc is CW bits and never overflows, because the maximum count is WIDTH.
  - Padding bits above WIDTH are always 0.
- WIDTH not a multiple of 3: the top chunk contains only the valid bits plus zero padding, and the count is unaffected.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

Optional Feature:
- Macro: POPCOUNT_SEQ_EARLY_EXIT_EN.
- Defined: in RUN, after adding the current chunk, if the shifted remainder (sh >> 3) is all zero, go to DONE immediately.
  - Latency becomes 1 + the index of the highest nonzero chunk, minimum 1 cycle (a zero word takes 1 RUN cycle).
  - Results are identical to the undefined case.
- Undefined: RUN always lasts exactly NCHUNK cycles, independent of the data.

Test Plan (WIDTH=16):
- Full word: accept 16'hFFFF, out_ready=1 -> out_count=16; out_valid rises 6 cycles after the accept edge; in_ready=0 for the whole operation.
- Zero word: accept 16'h0000 -> out_count=0.
  - Latency is 6 cycles without the macro, 1 cycle with POPCOUNT_SEQ_EARLY_EXIT_EN.
- Padding/extremes: accept 16'h8001 -> out_count=2; latency 6 in both builds, because bit 15 lies in chunk 5.
  - Accept 16'h0007 -> out_count=3; latency 6 without the macro, 1 with it.
- Backpressure: 16'hA5A5 with out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_count stays 8.
  - in_valid=1 with new data during that time is not accepted.
  - Raising out_ready gives IDLE next cycle, then the new word is accepted.
- Reset mid-run: accept 16'h00FF, assert reset on RUN cycle 3 -> next cycle state=IDLE, out_valid=0, out_count=0, in_ready=1.
  - A subsequent 16'h0F0F yields out_count=8.
- Back-to-back random: 200 random words with random out_ready -> every out_count equals the popcount of the accepted word; no word is lost or duplicated.
